// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioning path.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_t;

  localparam int unsigned DEBOUNCE_20MS = 1000000;
  localparam int unsigned DEBOUNCE_SIM  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset loads RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces a raw key and emits one-cycle press/release pulses plus a level.
// Press-to-pulse latency is DEBOUNCE_CYCLES+3 edges from the first sample.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK_50M,
  input  logic RST_N,
  input  logic KEY_IN,
  output logic KEY_LEVEL,
  output logic KEY_PULSE,
  output logic KEY_RELEASE
);

  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic                 IDLE_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic             key_sync;
  logic             key_s;
  logic [CNT_W-1:0] cnt;
  key_state_t       state;

  sync_2ff #(
    .RST_VAL (IDLE_LVL)
  ) u_sync (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .d     (KEY_IN),
    .q     (key_sync)
  );

  // Normalise so key_s = 1 always means pressed.
  assign key_s = key_sync ^ IDLE_LVL;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      KEY_LEVEL   <= 1'b0;
      KEY_PULSE   <= 1'b0;
      KEY_RELEASE <= 1'b0;
    end else begin
      KEY_PULSE   <= 1'b0;
      KEY_RELEASE <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          // A flip on the terminal count is still a bounce: check level first.
          if (!key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            KEY_PULSE <= 1'b1;
            KEY_LEVEL <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            KEY_RELEASE <= 1'b1;
            KEY_LEVEL   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with an 8-cycle debounce window.
module tb_key_debounce_pulse;
  import key_pkg::*;

  localparam int LAT = DEBOUNCE_SIM + 3;

  logic CLK_50M = 1'b0;
  logic RST_N;
  logic KEY_IN;
  logic KEY_LEVEL;
  logic KEY_PULSE;
  logic KEY_RELEASE;

  int vectors     = 0;
  int miscompares = 0;

  // Downstream modulo-3 event counter driven by KEY_PULSE.
  logic       ds_rst = 1'b1;
  logic [1:0] ds_cnt;
  logic       ds_z;

  always #10 CLK_50M = ~CLK_50M;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK_50M     (CLK_50M),
    .RST_N       (RST_N),
    .KEY_IN      (KEY_IN),
    .KEY_LEVEL   (KEY_LEVEL),
    .KEY_PULSE   (KEY_PULSE),
    .KEY_RELEASE (KEY_RELEASE)
  );

  always @(posedge CLK_50M) begin
    if (ds_rst) begin
      ds_cnt <= 2'd0;
      ds_z   <= 1'b0;
    end else begin
      ds_z <= KEY_PULSE && (ds_cnt == 2'd2);
      if (KEY_PULSE) ds_cnt <= (ds_cnt == 2'd2) ? 2'd0 : ds_cnt + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic pls, input logic rel);
    check({tag, ".level"},   {31'd0, KEY_LEVEL},   {31'd0, lvl});
    check({tag, ".pulse"},   {31'd0, KEY_PULSE},   {31'd0, pls});
    check({tag, ".release"}, {31'd0, KEY_RELEASE}, {31'd0, rel});
  endtask

  // Edge 1 is the next edge after this call; pulse expected after edge LAT only.
  task automatic watch_press(input string tag, input int z_edge);
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      check_outs($sformatf("%s.e%0d", tag, e), e >= LAT, e == LAT, 1'b0);
      check($sformatf("%s.z%0d", tag, e), {31'd0, ds_z}, {31'd0, e == z_edge});
    end
  endtask

  task automatic watch_release(input string tag);
    KEY_IN = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      check_outs($sformatf("%s.e%0d", tag, e), e < LAT, 1'b0, e == LAT);
      check($sformatf("%s.z%0d", tag, e), {31'd0, ds_z}, 32'd0);
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    KEY_IN = 1'b1;
    repeat (3) @(posedge CLK_50M);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset.state", {30'd0, dut.state}, {30'd0, IDLE});
    RST_N = 1'b1;

    // 1: idle with key released
    for (int i = 0; i < 50; i++) begin
      step();
      check_outs($sformatf("idle.c%0d", i), 1'b0, 1'b0, 1'b0);
    end
    check("idle.state", {30'd0, dut.state}, {30'd0, IDLE});

    // 2: clean press, then hold and confirm no second pulse
    KEY_IN = 1'b0;
    watch_press("clean_press", 0);
    for (int i = 0; i < 30; i++) begin
      step();
      check_outs($sformatf("hold.c%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // 4: clean release
    watch_release("clean_release");

    // 3: bouncy press, segments of 3 cycles are too short to qualify
    for (int seg = 0; seg < 10; seg++) begin
      KEY_IN = seg[0];
      for (int i = 0; i < 3; i++) begin
        step();
        check_outs($sformatf("bounce.s%0d.c%0d", seg, i), 1'b0, 1'b0, 1'b0);
      end
    end
    KEY_IN = 1'b0;
    watch_press("bouncy_press", 0);
    watch_release("bouncy_release");

    // 5: reset while in PRESS_WAIT at cnt = 5
    KEY_IN = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    check("midrst.pre_state", {30'd0, dut.state}, {30'd0, PRESS_WAIT});
    check("midrst.pre_cnt", 32'(dut.cnt), 32'd5);
    #4;
    RST_N = 1'b0;
    #1;
    check_outs("midrst.async", 1'b0, 1'b0, 1'b0);
    check("midrst.state", {30'd0, dut.state}, {30'd0, IDLE});
    check("midrst.cnt", 32'(dut.cnt), 32'd0);
    repeat (3) @(posedge CLK_50M);
    #1;
    RST_N = 1'b1;
    watch_press("post_reset_press", 0);
    watch_release("post_reset_release");

    // 6: three presses into the downstream modulo-3 counter
    ds_rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      KEY_IN = 1'b0;
      watch_press($sformatf("ds_press%0d", p), (p == 2) ? LAT + 1 : 0);
      watch_release($sformatf("ds_release%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
